// File: rtl/weight_loader.sv
// Streams weight words over valid/ready, packs `size` words per row and issues one-cycle row writes
// for every row of every layer. Optional running checksum: define WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int unsigned data_size  = 16,
  parameter int unsigned size       = 3,
  parameter int unsigned layer_size = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [data_size-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [31:0]                 write_layer_index,
  output logic [31:0]                 write_row_index,
  output logic [data_size*size-1:0]   write_data,
  output logic                        is_write,
  output logic                        busy,
  output logic                        done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [data_size-1:0]        checksum
`endif
);

  localparam int unsigned CNT_W = (size > 1) ? $clog2(size) : 1;
  localparam int unsigned LYR_W = (layer_size > 1) ? $clog2(layer_size) : 1;
  localparam int unsigned ROW_W = data_size * size;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic [CNT_W-1:0]   row_cnt_q;
  logic [LYR_W-1:0]   layer_cnt_q;
  logic [ROW_W-1:0]   data_q;
  logic [ROW_W-1:0]   data_d;
  logic [31:0]        wr_row_q;
  logic [31:0]        wr_layer_q;
  logic               is_write_q;
  logic               done_q;
  logic               accept_c;
  logic               word_last_c;
  logic               row_last_c;
  logic               layer_last_c;

  assign accept_c     = in_valid && (state_q == S_LOAD);
  assign word_last_c  = (word_cnt_q == CNT_W'(size - 1));
  assign row_last_c   = (row_cnt_q == CNT_W'(size - 1));
  assign layer_last_c = (layer_cnt_q == LYR_W'(layer_size - 1));

  // Row buffer with the incoming word dropped into column word_cnt (column 0 in the MSB slice)
  always_comb begin
    data_d = data_q;
    for (int unsigned k = 0; k < size; k++) begin
      if (word_cnt_q == CNT_W'(k)) begin
        data_d[(size-k)*data_size-1 -: data_size] = in_data;
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [data_size-1:0] checksum_q;
  logic [data_size-1:0] checksum_d;
  assign checksum_d = checksum_q + in_data;
  assign checksum   = checksum_q;
`endif

  // Control FSM with all counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      row_cnt_q   <= '0;
      layer_cnt_q <= '0;
      data_q      <= '0;
      wr_row_q    <= '0;
      wr_layer_q  <= '0;
      is_write_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      is_write_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            word_cnt_q  <= '0;
            row_cnt_q   <= '0;
            layer_cnt_q <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (accept_c) begin
            data_q <= data_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
            if (word_last_c) begin
              state_q    <= S_WRITE;
              is_write_q <= 1'b1;
              wr_row_q   <= 32'(row_cnt_q);
              wr_layer_q <= 32'(layer_cnt_q);
            end else begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
          end
        end
        S_WRITE: begin
          word_cnt_q <= '0;
          if (!row_last_c) begin
            row_cnt_q <= row_cnt_q + CNT_W'(1);
            state_q   <= S_LOAD;
          end else begin
            row_cnt_q <= '0;
            if (!layer_last_c) begin
              layer_cnt_q <= layer_cnt_q + LYR_W'(1);
              state_q     <= S_LOAD;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready          = (state_q == S_LOAD);
  assign busy              = (state_q != S_IDLE);
  assign is_write          = is_write_q;
  assign done              = done_q;
  assign write_data        = data_q;
  assign write_row_index   = wr_row_q;
  assign write_layer_index = wr_layer_q;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: scenario table driven against a row-packing reference model.
module tb_weight_loader;

  localparam int unsigned DW     = 16;
  localparam int unsigned SZ     = 3;
  localparam int unsigned LS     = 5;
  localparam int unsigned NROWS  = SZ * LS;
  localparam int unsigned NWORDS = NROWS * SZ;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [DW-1:0]      in_data;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        write_layer_index;
  logic [31:0]        write_row_index;
  logic [DW*SZ-1:0]   write_data;
  logic               is_write;
  logic               busy;
  logic               done;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DW-1:0]      checksum;
`endif

  weight_loader #(.data_size(DW), .size(SZ), .layer_size(LS)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .write_layer_index (write_layer_index),
    .write_row_index   (write_row_index),
    .write_data        (write_data),
    .is_write          (is_write),
    .busy              (busy),
    .done              (done)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  always #5 clk = ~clk;

  int unsigned ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  typedef struct {
    int wsel;        // 0: words 1..N, 1: all 0xFFFF, 2: random
    int vmode;       // 0: valid held high, 1: toggling, 2: random gaps
    bit noise;       // random start pulses while busy
    int abort_words; // assert reset once this many words accepted (-1: never)
    int abort_write; // assert reset during the n-th write cycle (-1: never)
    int exp_writes;
  } scen_t;

  typedef struct {
    int              idx;
    logic [31:0]     layer;
    logic [31:0]     row;
    logic [DW*SZ-1:0] data;
    int              cyc;
  } vec_t;

  scen_t scen[8];
  vec_t  vecs[4];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    words[$];
  logic [31:0]      got_layer[$];
  logic [31:0]      got_row[$];
  logic [DW*SZ-1:0] got_data[$];
  int               got_cyc[$];
  int               done_cnt;
  int               done_cyc;
  int               idle_cyc;
  logic [31:0]      last_row = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sync reset with start/valid active; everything must be back at reset values
  task automatic reset_dut();
    rst_n    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    @(negedge clk);
    chk("rst_is_write", 64'(is_write), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_data", 64'(write_data), 64'(0));
    chk("rst_row", 64'(write_row_index), 64'(0));
    chk("rst_layer", 64'(write_layer_index), 64'(0));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum), 64'(0));
`endif
    start    = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    last_row = '0;
    @(negedge clk);
    chk("post_rst_idle", 64'({busy, is_write}), 64'(0));
  endtask

  task automatic run(input scen_t s, input int sid);
    int unsigned t0;
    int idx;
    int rel;
    bit fin;
    bit aborted;
    bit acc;
    bit v;
    logic [DW-1:0]    exp_sum;
    logic [DW*SZ-1:0] exp_data;
    idx = 0; fin = 1'b0; aborted = 1'b0; exp_sum = '0;
    words.delete(); got_layer.delete(); got_row.delete(); got_data.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; idle_cyc = -1;
    for (int i = 0; i < int'(NWORDS); i++) begin
      case (s.wsel)
        0:       words.push_back(DW'(i + 1));
        1:       words.push_back('1);
        default: words.push_back(DW'($urandom));
      endcase
    end
    t0 = ncyc;
    for (int c = 0; c < 2000 && !fin; c++) begin
      case (s.vmode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v && (idx < int'(NWORDS));
      in_data  = in_valid ? words[idx] : DW'($urandom);
      start    = (c == 0) || (s.noise && $urandom_range(0, 3) == 0);
      acc      = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
      rel = int'(ncyc - t0);
      chk("in_ready_state", 64'(in_ready), 64'(busy && !is_write && !done));
      if (is_write) begin
        got_layer.push_back(write_layer_index);
        got_row.push_back(write_row_index);
        got_data.push_back(write_data);
        got_cyc.push_back(rel);
        last_row = write_row_index;
      end else begin
        chk("row_hold", 64'(write_row_index), 64'(last_row));
      end
      if (done) begin
        done_cnt++;
        done_cyc = rel;
      end
      if (s.abort_words >= 0 && idx == s.abort_words) begin
        reset_dut();
        aborted = 1'b1;
        fin     = 1'b1;
      end else if (s.abort_write >= 0 && is_write && got_data.size() == s.abort_write) begin
        reset_dut();
        aborted = 1'b1;
        fin     = 1'b1;
      end else if (done_cnt > 0 && !busy) begin
        fin      = 1'b1;
        idle_cyc = rel;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout scen %0d: no return to idle, got %0d writes expected %0d", sid,
               got_data.size(), s.exp_writes);
    end
    chk($sformatf("s%0d_n_writes", sid), 64'(got_data.size()), 64'(s.exp_writes));
    for (int i = 0; i < got_data.size() && i < s.exp_writes; i++) begin
      exp_data = {words[SZ*i], words[SZ*i+1], words[SZ*i+2]};
      chk($sformatf("s%0d_w%0d_layer", sid, i), 64'(got_layer[i]), 64'(i / SZ));
      chk($sformatf("s%0d_w%0d_row", sid, i), 64'(got_row[i]), 64'(i % SZ));
      chk($sformatf("s%0d_w%0d_data", sid, i), 64'(got_data[i]), 64'(exp_data));
    end
    if (!aborted) begin
      chk($sformatf("s%0d_words_used", sid), 64'(idx), 64'(NWORDS));
      chk($sformatf("s%0d_done_cnt", sid), 64'(done_cnt), 64'(1));
      if (s.vmode == 0) begin
        for (int i = 0; i < got_cyc.size(); i++)
          chk($sformatf("s%0d_w%0d_cycle", sid, i), 64'(got_cyc[i]), 64'((SZ + 1) * (i + 1)));
        chk($sformatf("s%0d_done_cycle", sid), 64'(done_cyc), 64'(61));
        chk($sformatf("s%0d_idle_cycle", sid), 64'(idle_cyc), 64'(62));
      end
      if (s.wsel == 0 && s.vmode == 0) begin
        foreach (vecs[j]) begin
          if (vecs[j].idx < got_data.size()) begin
            chk($sformatf("vec%0d_layer", j), 64'(got_layer[vecs[j].idx]), 64'(vecs[j].layer));
            chk($sformatf("vec%0d_row", j), 64'(got_row[vecs[j].idx]), 64'(vecs[j].row));
            chk($sformatf("vec%0d_data", j), 64'(got_data[vecs[j].idx]), 64'(vecs[j].data));
            chk($sformatf("vec%0d_cycle", j), 64'(got_cyc[vecs[j].idx]), 64'(vecs[j].cyc));
          end
        end
      end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      foreach (words[i]) exp_sum = exp_sum + words[i];
      chk($sformatf("s%0d_checksum", sid), 64'(checksum), 64'(exp_sum));
`endif
    end else begin
      chk($sformatf("s%0d_abort_no_done", sid), 64'(done_cnt), 64'(0));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scen[0] = '{0, 0, 1'b0, -1, -1, 15};
    scen[1] = '{0, 1, 1'b0, -1, -1, 15};
    scen[2] = '{2, 0, 1'b1, -1, -1, 15};
    scen[3] = '{0, 0, 1'b0, 14, -1, 4};
    scen[4] = '{2, 2, 1'b1, -1, -1, 15};
    scen[5] = '{2, 2, 1'b0, -1, 7, 7};
    scen[6] = '{0, 0, 1'b0, -1, -1, 15};
    scen[7] = '{1, 2, 1'b0, -1, -1, 15};

    vecs[0] = '{0,  32'd0, 32'd0, 48'h0001_0002_0003, 4};
    vecs[1] = '{2,  32'd0, 32'd2, 48'h0007_0008_0009, 12};
    vecs[2] = '{3,  32'd1, 32'd0, 48'h000A_000B_000C, 16};
    vecs[3] = '{14, 32'd4, 32'd2, 48'h002B_002C_002D, 60};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("init_is_write", 64'(is_write), 64'(0));
    chk("init_done", 64'(done), 64'(0));
    chk("init_busy", 64'(busy), 64'(0));
    chk("init_in_ready", 64'(in_ready), 64'(0));
    chk("init_data", 64'(write_data), 64'(0));
    chk("init_indices", 64'({write_layer_index, write_row_index}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    foreach (scen[i]) begin
      run(scen[i], i);
      repeat (2) @(negedge clk);
    end

    // Idle: valid words without start are neither accepted nor written
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'(0));
      chk("idle_is_write", 64'({is_write, busy}), 64'(0));
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
